// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: flag/abort detection, zero de-stuffing, LSB-first byte
// assembly and frame event reporting toward the packet buffer.
module hdlc_rx_framer #(
  parameter int MIN_BYTES = 2,
  parameter int MAX_BYTES = 256,
  parameter int CW        = $clog2(MAX_BYTES+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          w,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  output logic          frame_start,
  output logic          frame_end,
  output logic          frame_abort,
  output logic          frame_error,
  output logic          in_frame,
  output logic [CW-1:0] byte_count
);

  typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ones_q, ones_d;
  logic [6:0]    dl_q, dl_d;
  logic [2:0]    dl_cnt_q, dl_cnt_d;
  logic [7:0]    asm_q, asm_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          bv_q, bv_d, fs_q, fs_d, fe_q, fe_d, fa_q, fa_d, ferr_q, ferr_d;

  logic is_abort, is_flag, is_stuff;

  // Bit classification against the run of preceding raw 1s.
  assign is_abort = w  & (ones_q == 3'd6);
  assign is_flag  = !w & (ones_q == 3'd6);
  assign is_stuff = !w & (ones_q == 3'd5);

  // Next-state, de-stuffing, delay line, assembler and event generation.
  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    dl_d       = dl_q;
    dl_cnt_d   = dl_cnt_q;
    asm_d      = asm_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    byte_out_d = byte_out_q;
    bv_d       = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    fa_d       = 1'b0;
    ferr_d     = 1'b0;
    if (en) begin
      ones_d = !w ? 3'd0 : (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
      if (state_q == HUNT) begin
        if (is_flag) begin
          state_d   = SYNC;
          dl_cnt_d  = 3'd0;
          bit_cnt_d = 3'd0;
          cnt_d     = '0;
        end
      end else if (is_abort) begin
        fa_d      = (state_q == DATA);
        state_d   = HUNT;
        dl_cnt_d  = 3'd0;
        bit_cnt_d = 3'd0;
      end else if (is_flag) begin
        // The closing flag doubles as the opening flag of the next frame.
        if (state_q == DATA) begin
          if (bit_cnt_q == 3'd0 && 32'(cnt_q) >= MIN_BYTES) fe_d = 1'b1;
          else ferr_d = 1'b1;
        end
        state_d   = SYNC;
        dl_cnt_d  = 3'd0;
        bit_cnt_d = 3'd0;
      end else if (!is_stuff) begin
        // Seven-bit hold-back keeps the leading bits of a closing flag out of
        // the assembler; only the bit leaving a full line is real payload.
        dl_d = {w, dl_q[6:1]};
        if (dl_cnt_q != 3'd7) begin
          dl_cnt_d = dl_cnt_q + 3'd1;
        end else begin
          asm_d     = {dl_q[0], asm_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == SYNC) begin
              state_d    = DATA;
              bv_d       = 1'b1;
              fs_d       = 1'b1;
              byte_out_d = asm_d;
              cnt_d      = {{(CW-1){1'b0}}, 1'b1};
            end else if (32'(cnt_q) == MAX_BYTES) begin
              ferr_d   = 1'b1;
              state_d  = HUNT;
              dl_cnt_d = 3'd0;
            end else begin
              bv_d       = 1'b1;
              byte_out_d = asm_d;
              cnt_d      = cnt_q + 1'b1;
            end
          end
        end
      end
    end
  end

  // State and output registers; reset drops any partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      ones_q     <= 3'd0;
      dl_q       <= 7'd0;
      dl_cnt_q   <= 3'd0;
      asm_q      <= 8'd0;
      bit_cnt_q  <= 3'd0;
      cnt_q      <= '0;
      byte_out_q <= 8'd0;
      bv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      fa_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      dl_q       <= dl_d;
      dl_cnt_q   <= dl_cnt_d;
      asm_q      <= asm_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      byte_out_q <= byte_out_d;
      bv_q       <= bv_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      fa_q       <= fa_d;
      ferr_q     <= ferr_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = bv_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign frame_abort = fa_q;
  assign frame_error = ferr_q;
  assign in_frame    = (state_q == DATA);
  assign byte_count  = cnt_q;

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Directed bench for hdlc_rx_framer: bit-serial stimulus with a transmit-side
// stuffing helper; DUT events are logged and compared to hand-built lists.
module tb_hdlc_rx_framer;
  localparam int CW = $clog2(4+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          w = 1'b0;
  logic [7:0]    byte_out;
  logic          byte_valid, frame_start, frame_end, frame_abort, frame_error, in_frame;
  logic [CW-1:0] byte_count;

  hdlc_rx_framer #(.MIN_BYTES(2), .MAX_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .w(w),
    .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start),
    .frame_end(frame_end), .frame_abort(frame_abort), .frame_error(frame_error),
    .in_frame(in_frame), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // event kinds
  localparam logic [3:0] K_BYTE = 4'd1, K_START = 4'd2, K_END = 4'd3,
                         K_ABORT = 4'd4, K_ERR = 4'd5, K_LONE_START = 4'd6;

  int n_chk = 0;
  int n_err = 0;
  int gap = 0;
  int tx_ones = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Event logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid)
        got_q.push_back({(frame_start ? K_START : K_BYTE), 3'b0, in_frame, byte_out});
      else if (frame_start)
        got_q.push_back({K_LONE_START, 3'b0, in_frame, byte_out});
      if (frame_end)   got_q.push_back({K_END,   3'b0, in_frame, 8'(byte_count)});
      if (frame_abort) got_q.push_back({K_ABORT, 3'b0, in_frame, 8'(byte_count)});
      if (frame_error) got_q.push_back({K_ERR,   3'b0, in_frame, 8'(byte_count)});
    end
  end

  task automatic ex(input logic [3:0] k, input logic infr, input logic [7:0] d);
    exp_q.push_back({k, 3'b0, infr, d});
  endtask

  task automatic send_bit(input logic b);
    en = 1'b1;
    w  = b;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 5) begin
      send_bit(1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_data_bit(b[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    tx_ones = 0;
  endtask

  task automatic send_raw(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic check_events(input string tag);
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_byte_out", byte_out, 0);
    chk("rst_pulses", {byte_valid, frame_start, frame_end, frame_abort, frame_error}, 0);
    chk("rst_in_frame", in_frame, 0);
    chk("rst_byte_count", byte_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: idle ones, flag, A5 3C, flag
    send_raw(32'h3FF, 10);
    send_flag(); send_byte(8'hA5); send_byte(8'h3C); send_flag();
    ex(K_START, 1, 8'hA5); ex(K_BYTE, 1, 8'h3C); ex(K_END, 0, 8'd2);
    check_events("t1");
    chk("t1_byte_count", byte_count, 2);
    chk("t1_in_frame", in_frame, 0);

    // 2: FF and 7E with hand-stuffed raw bits
    send_flag();
    send_raw(32'b01_0111_1101_1101_1111, 18);
    send_flag();
    ex(K_START, 1, 8'hFF); ex(K_BYTE, 1, 8'h7E); ex(K_END, 0, 8'd2);
    check_events("t2");

    // 3: abort mid-frame, then a good frame
    send_flag(); send_byte(8'h55); send_byte(8'hAA);
    send_raw(32'h7F, 7);
    ex(K_START, 1, 8'h55); ex(K_ABORT, 0, 8'd1);
    check_events("t3a");
    send_flag(); send_byte(8'h12); send_byte(8'h34); send_flag();
    ex(K_START, 1, 8'h12); ex(K_BYTE, 1, 8'h34); ex(K_END, 0, 8'd2);
    check_events("t3b");

    // 4: repeated flags and a shared flag
    send_flag(); send_flag(); send_flag();
    send_byte(8'h12); send_byte(8'h34); send_flag();
    send_byte(8'h56); send_byte(8'h78); send_flag();
    ex(K_START, 1, 8'h12); ex(K_BYTE, 1, 8'h34); ex(K_END, 0, 8'd2);
    ex(K_START, 1, 8'h56); ex(K_BYTE, 1, 8'h78); ex(K_END, 0, 8'd2);
    check_events("t4");

    // 5a: runt
    send_flag(); send_byte(8'h12); send_flag();
    ex(K_START, 1, 8'h12); ex(K_ERR, 0, 8'd1);
    check_events("t5a");
    // 5b: misaligned
    send_flag(); send_byte(8'h12); send_byte(8'h34);
    send_data_bit(1); send_data_bit(0); send_data_bit(1); send_data_bit(0);
    send_flag();
    ex(K_START, 1, 8'h12); ex(K_BYTE, 1, 8'h34); ex(K_ERR, 0, 8'd2);
    check_events("t5b");
    // 5c: oversize, fifth byte flushed through by zeros
    send_flag();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    for (int i = 0; i < 7; i++) send_data_bit(1'b0);
    ex(K_START, 1, 8'h01); ex(K_BYTE, 1, 8'h02); ex(K_BYTE, 1, 8'h03); ex(K_BYTE, 1, 8'h04);
    ex(K_ERR, 0, 8'd4);
    check_events("t5c");
    chk("t5c_byte_count", byte_count, 4);

    // 6: reset mid-byte
    send_flag(); send_byte(8'h12); send_byte(8'h34);
    send_data_bit(1); send_data_bit(0); send_data_bit(1);
    chk("t6_pre_in_frame", in_frame, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_frame", in_frame, 0);
    chk("t6_rst_byte_count", byte_count, 0);
    chk("t6_rst_byte_out", byte_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ex(K_START, 1, 8'h12);
    check_events("t6a");
    // HUNT ignores data until a flag; then a gated run
    gap = 3;
    send_byte(8'h56);
    send_flag(); send_byte(8'h12); send_byte(8'h34); send_flag();
    gap = 0;
    ex(K_START, 1, 8'h12); ex(K_BYTE, 1, 8'h34); ex(K_END, 0, 8'd2);
    check_events("t6b");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
